// File: rtl/csr_tap_trace_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_tap_trace_sequencer_if
// Description : Bundle of the CSR tap snapshot input and the serialized trace
//               word stream produced by csr_tap_trace_sequencer.
//               master : the environment (drives snapshots, accepts words)
//               slave  : the sequencer
// Ports       : snap_valid / snap_data            snapshot strobe and data
//               out_valid / out_ready / out_data  trace word stream
//               out_last                          final word of a packet
//               overflow_cnt                      dropped-snapshot count
//               busy                              work pending or in flight
// Revision    : 1.0  initial release
// ============================================================================
interface csr_tap_trace_sequencer_if #(
    parameter int SNAP_W = 143,
    parameter int OUT_W  = 32
);
    logic              snap_valid;
    logic [SNAP_W-1:0] snap_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic [15:0]       overflow_cnt;
    logic              busy;

    modport master (
        output snap_valid, snap_data, out_ready,
        input  out_valid, out_data, out_last, overflow_cnt, busy
    );

    modport slave (
        input  snap_valid, snap_data, out_ready,
        output out_valid, out_data, out_last, overflow_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/csr_tap_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csr_tap_trace_sequencer
// Description : Captures a CSR snapshot on every retire strobe into a small
//               FIFO and serializes each entry as a packet of OUT_W-bit words
//               on a valid/ready stream. Snapshots arriving while the FIFO is
//               full (and nothing is popped) are dropped and counted.
// Ports       : clock    single clock, rising edge
//               reset_n  asynchronous active-low reset
//               bus      csr_tap_trace_sequencer_if.slave (snapshot in,
//                        word stream out, overflow_cnt, busy)
// Options     : CSR_TAP_TRACE_TIMESTAMP_EN - prepends a 32-bit free-running
//               cycle timestamp (captured at push) as word 0 of each packet.
//               Timestamp mode assumes OUT_W >= 32.
// Revision    : 1.0  initial release
// ============================================================================
module csr_tap_trace_sequencer #(
    parameter int SNAP_W     = 143,
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_W      = 32
) (
    input  wire logic                clock,
    input  wire logic                reset_n,
    csr_tap_trace_sequencer_if.slave bus
);
    localparam int c_NW = (SNAP_W + OUT_W - 1) / OUT_W;
`ifdef CSR_TAP_TRACE_TIMESTAMP_EN
    localparam int c_TS_W   = 32;
    localparam int c_LEAD_W = OUT_W;        // word 0 carries the timestamp
    localparam int c_NWORDS = c_NW + 1;
`else
    localparam int c_TS_W   = 0;
    localparam int c_LEAD_W = 0;
    localparam int c_NWORDS = c_NW;
`endif
    localparam int c_ENT_W  = SNAP_W + c_TS_W;
    localparam int c_PKT_W  = c_NWORDS * OUT_W;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_IDX_W  = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NWORDS - 1);
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [c_PKT_W-1:0]   r_pkt;
    logic [15:0]          r_ovf;
    logic [c_ENT_W-1:0]   w_push_entry;
    logic [c_ENT_W-1:0]   w_head;
    logic [c_PKT_W-1:0]   w_pkt_image;
    logic [OUT_W-1:0]     w_words [c_NWORDS];
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_send;

    // ------------------------------------------------------------------
    // Entry assembly (timestamp sits in the low bits of the entry)
    // ------------------------------------------------------------------
`ifdef CSR_TAP_TRACE_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ts <= 32'd0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    assign w_push_entry = {bus.snap_data, r_ts};
`else
    assign w_push_entry = bus.snap_data;
`endif

    // ------------------------------------------------------------------
    // Snapshot FIFO
    // ------------------------------------------------------------------
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = bus.snap_valid && (!w_full || w_pop);
    assign w_drop  = bus.snap_valid && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet image: optional timestamp word, then snapshot, zero-padded
    // ------------------------------------------------------------------
    always_comb begin
        w_pkt_image = '0;
        w_pkt_image[c_LEAD_W +: SNAP_W] = w_head[c_ENT_W-1 -: SNAP_W];
`ifdef CSR_TAP_TRACE_TIMESTAMP_EN
        w_pkt_image[31:0] = w_head[31:0];
`endif
    end

    for (genvar gi = 0; gi < c_NWORDS; gi++) begin : g_words
        assign w_words[gi] = r_pkt[gi*OUT_W +: OUT_W];
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = '0;
                end
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        // Reload straight from the FIFO so packets run back-to-back.
                        w_idx_nxt = '0;
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pkt   <= '0;
            r_ovf   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_pop) begin
                r_pkt <= w_pkt_image;
            end
            if (w_drop && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_send           = (r_state == S_SEND);
    assign bus.out_valid    = w_send;
    assign bus.out_data     = w_send ? w_words[r_idx] : '0;
    assign bus.out_last     = w_send && (r_idx == c_LAST_IDX);
    assign bus.overflow_cnt = r_ovf;
    assign bus.busy         = !w_empty || w_send;

endmodule
`default_nettype wire

// File: tb/tb_csr_tap_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_tap_trace_sequencer
// Description : Directed self-checking bench for csr_tap_trace_sequencer.
//               Inputs change on the falling edge; outputs are compared on
//               the falling edge against hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_csr_tap_trace_sequencer;
    localparam int c_SNAP_W = 143;
    localparam int c_OUT_W  = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    csr_tap_trace_sequencer_if #(.SNAP_W(c_SNAP_W), .OUT_W(c_OUT_W)) bus ();

    csr_tap_trace_sequencer #(
        .SNAP_W     (c_SNAP_W),
        .FIFO_DEPTH (4),
        .OUT_W      (c_OUT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic l);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".data"},  bus.out_data, d);
        chk({tag, ".last"},  32'(bus.out_last), 32'(l));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".busy"},  32'(bus.busy), 32'd0);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Snapshot k: words 0..3 = {j+1 in top nibble, k}, word 4 = k.
    function automatic logic [c_SNAP_W-1:0] mk(input int k);
        return {15'(k), 32'h4000_0000 | 32'(k), 32'h3000_0000 | 32'(k),
                32'h2000_0000 | 32'(k), 32'h1000_0000 | 32'(k)};
    endfunction

    function automatic logic [31:0] exp_w(input int k, input int j);
        return (j == 4) ? 32'(k) : ({4'(j + 1), 28'h0} | 32'(k));
    endfunction

    logic [143:0]          pat;
    logic [c_SNAP_W-1:0]   s2;

    initial begin
        pat = {{17{8'h5A}}, 8'hA5};
        s2  = {15'h1234, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.snap_valid = 1'b0;
        bus.snap_data  = '0;
        bus.out_ready  = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst.valid", 32'(bus.out_valid), 32'd0);
        chk("rst.data",  bus.out_data, 32'd0);
        chk("rst.last",  32'(bus.out_last), 32'd0);
        chk("rst.ovf",   32'(bus.overflow_cnt), 32'd0);
        chk("rst.busy",  32'(bus.busy), 32'd0);
        reset_n = 1'b1;

`ifdef CSR_TAP_TRACE_TIMESTAMP_EN
        // Timestamp packet: push while the counter reads 100
        repeat (100) step();
        bus.snap_valid = 1'b1;
        bus.snap_data  = mk(11);
        step();
        bus.snap_valid = 1'b0;
        chk("t6.lat.valid", 32'(bus.out_valid), 32'd0);
        step();
        chk_word("t6.ts", 32'd100, 1'b0);
        for (int j = 0; j < 5; j++) begin
            step();
            chk_word($sformatf("t6.w%0d", j + 1), exp_w(11, j), (j == 4));
        end
        step();
        chk_idle("t6.end");
`else
        // 1: single snapshot, two-cycle latency, zero-padded last word
        step();
        bus.snap_valid = 1'b1;
        bus.snap_data  = pat[c_SNAP_W-1:0];
        step();
        bus.snap_valid = 1'b0;
        chk("t1.lat.valid", 32'(bus.out_valid), 32'd0);
        chk("t1.lat.busy",  32'(bus.busy), 32'd1);
        step(); chk_word("t1.w0", 32'h5A5A_5AA5, 1'b0);
        step(); chk_word("t1.w1", 32'h5A5A_5A5A, 1'b0);
        step(); chk_word("t1.w2", 32'h5A5A_5A5A, 1'b0);
        step(); chk_word("t1.w3", 32'h5A5A_5A5A, 1'b0);
        step(); chk_word("t1.w4", 32'h0000_5A5A, 1'b1);
        step(); chk_idle("t1.end");

        // 2: three stalled cycles on word 2
        bus.snap_valid = 1'b1;
        bus.snap_data  = s2;
        step();
        bus.snap_valid = 1'b0;
        step(); chk_word("t2.w0", 32'h1111_1111, 1'b0);
        step(); chk_word("t2.w1", 32'h2222_2222, 1'b0);
        step(); chk_word("t2.w2", 32'h3333_3333, 1'b0);
        bus.out_ready = 1'b0;
        step(); chk_word("t2.stall1", 32'h3333_3333, 1'b0);
        step(); chk_word("t2.stall2", 32'h3333_3333, 1'b0);
        step(); chk_word("t2.stall3", 32'h3333_3333, 1'b0);
        bus.out_ready = 1'b1;
        step(); chk_word("t2.w3", 32'h4444_4444, 1'b0);
        step(); chk_word("t2.w4", 32'h0000_1234, 1'b1);
        step(); chk_idle("t2.end");

        // 3: overflow with the stream stalled, then drain in order
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            bus.snap_valid = 1'b1;
            bus.snap_data  = mk(k);
            step();
        end
        bus.snap_valid = 1'b0;
        chk("t3.ovf", 32'(bus.overflow_cnt), 32'd2);
        chk_word("t3.held", exp_w(1, 0), 1'b0);
        bus.out_ready = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            for (int j = 0; j < 5; j++) begin
                chk_word($sformatf("t3.p%0d.w%0d", p, j), exp_w(p, j), (j == 4));
                step();
            end
        end
        chk_idle("t3.end");
        chk("t3.ovf.end", 32'(bus.overflow_cnt), 32'd2);

        // 4: back-to-back snapshots give ten contiguous words
        bus.snap_valid = 1'b1;
        bus.snap_data  = mk(8);
        step();
        bus.snap_data  = mk(9);
        step();
        bus.snap_valid = 1'b0;
        for (int p = 8; p <= 9; p++) begin
            for (int j = 0; j < 5; j++) begin
                chk_word($sformatf("t4.p%0d.w%0d", p, j), exp_w(p, j), (j == 4));
                step();
            end
        end
        chk_idle("t4.end");

        // 5: reset during word 2 clears everything at once
        bus.snap_valid = 1'b1;
        bus.snap_data  = mk(10);
        step();
        bus.snap_valid = 1'b0;
        step(); chk_word("t5.w0", exp_w(10, 0), 1'b0);
        step(); chk_word("t5.w1", exp_w(10, 1), 1'b0);
        step(); chk_word("t5.w2", exp_w(10, 2), 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("t5.rst.valid", 32'(bus.out_valid), 32'd0);
        chk("t5.rst.busy",  32'(bus.busy), 32'd0);
        chk("t5.rst.ovf",   32'(bus.overflow_cnt), 32'd0);
        chk("t5.rst.last",  32'(bus.out_last), 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_idle($sformatf("t5.after%0d", i));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
